// File: rtl/hid_axil_bridge.sv
// hid_axil_bridge: AXI4-Lite slave that turns CPU MMIO accesses into the
// single-cycle hid bus consumed by periph_soc. One access is in flight at a
// time; read data is captured RD_LAT cycles after the hid strobe.
//
// Ports:
//   msoc_clk, rstn           clock, asynchronous active-low reset
//   s_aw*/s_w*/s_b*          AXI4-Lite write address/data/response channels
//   s_ar*/s_r*               AXI4-Lite read address/data channels
//   hid_en                   one-cycle access strobe per accepted transaction
//   hid_we                   byte write enables (0 on reads and when idle)
//   hid_addr, hid_wrdata     access address and write data (held between accesses)
//   hid_rddata               read data, valid RD_LAT cycles after hid_en
module hid_axil_bridge #(
  parameter logic [31:0] BASE   = 32'h4100_0000,
  parameter int unsigned HID_AW = 18,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              msoc_clk,
  input  logic              rstn,
  input  logic [31:0]       s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [63:0]       s_wdata,
  input  logic [7:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [31:0]       s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [63:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic              hid_en,
  output logic [7:0]        hid_we,
  output logic [HID_AW-1:0] hid_addr,
  output logic [63:0]       hid_wrdata,
  input  logic [63:0]       hid_rddata
);

  localparam int unsigned CNT_W       = 2;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE, WR_CAP, WR_ISSUE, WR_RESP, RD_ISSUE, RD_WAIT, RD_RESP
  } state_e;

  state_e              state_q, state_d;
  logic                arb_wr_q, arb_wr_d;
  logic                hit_q, hit_d;
  logic [HID_AW-1:0]   addr_q, addr_d;
  logic [63:0]         wdata_q, wdata_d;
  logic [7:0]          strb_q, strb_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                hid_en_q, hid_en_d;
  logic [7:0]          hid_we_q, hid_we_d;
  logic [HID_AW-1:0]   hid_addr_q, hid_addr_d;
  logic [63:0]         hid_wrdata_q, hid_wrdata_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                rvalid_q, rvalid_d;
  logic [1:0]          rresp_q, rresp_d;
  logic [63:0]         rdata_q, rdata_d;

  logic aw_hit_c, ar_hit_c, wr_elig_c, rd_elig_c, wr_acc_c, rd_acc_c;

  // Window decode on the upper address bits
  assign aw_hit_c = (s_awaddr[31:HID_AW] == BASE[31:HID_AW]);
  assign ar_hit_c = (s_araddr[31:HID_AW] == BASE[31:HID_AW]);

  // Eligibility is gated by rstn so no ready can be seen while in reset
  assign wr_elig_c = rstn & s_awvalid & s_wvalid;
  assign rd_elig_c = rstn & s_arvalid;

  // Round-robin arbitration between complete write and read requests
  assign wr_acc_c = (state_q == IDLE) & wr_elig_c & (arb_wr_q | ~rd_elig_c);
  assign rd_acc_c = (state_q == IDLE) & rd_elig_c & ~wr_acc_c;

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    arb_wr_d     = arb_wr_q;
    hit_d        = hit_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    strb_d       = strb_q;
    cnt_d        = cnt_q;
    hid_en_d     = 1'b0;
    hid_we_d     = 8'h00;
    hid_addr_d   = hid_addr_q;
    hid_wrdata_d = hid_wrdata_q;
    bvalid_d     = bvalid_q;
    bresp_d      = bresp_q;
    rvalid_d     = rvalid_q;
    rresp_d      = rresp_q;
    rdata_d      = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (wr_acc_c) begin
          hit_d   = aw_hit_c;
          addr_d  = s_awaddr[HID_AW-1:0];
          wdata_d = s_wdata;
          strb_d  = s_wstrb;
          state_d = WR_CAP;
        end else if (rd_acc_c) begin
          hit_d   = ar_hit_c;
          addr_d  = s_araddr[HID_AW-1:0];
          // Strobe is registered here so it is visible during RD_ISSUE
          if (ar_hit_c) begin
            hid_en_d   = 1'b1;
            hid_addr_d = s_araddr[HID_AW-1:0];
          end
          state_d = RD_ISSUE;
        end
      end
      WR_CAP: begin
        if (hit_q) begin
          hid_en_d     = 1'b1;
          hid_we_d     = strb_q;
          hid_addr_d   = addr_q;
          hid_wrdata_d = wdata_q;
          state_d      = WR_ISSUE;
        end else begin
          bvalid_d = 1'b1;
          bresp_d  = RESP_SLVERR;
          state_d  = WR_RESP;
        end
      end
      WR_ISSUE: begin
        bvalid_d = 1'b1;
        bresp_d  = RESP_OKAY;
        state_d  = WR_RESP;
      end
      WR_RESP: begin
        if (s_bready) begin
          bvalid_d = 1'b0;
          arb_wr_d = 1'b0;
          state_d  = IDLE;
        end
      end
      RD_ISSUE: begin
        cnt_d = CNT_W'(RD_LAT - 1);
        if (hit_q) begin
          state_d = RD_WAIT;
        end else begin
          rvalid_d = 1'b1;
          rresp_d  = RESP_SLVERR;
          rdata_d  = 64'h0;
          state_d  = RD_RESP;
        end
      end
      RD_WAIT: begin
        // cnt_q reaches 0 in the cycle the access is RD_LAT cycles old
        if (cnt_q == '0) begin
          rdata_d  = hid_rddata;
          rresp_d  = RESP_OKAY;
          rvalid_d = 1'b1;
          state_d  = RD_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RD_RESP: begin
        if (s_rready) begin
          rvalid_d = 1'b0;
          arb_wr_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      arb_wr_q     <= 1'b1;
      hit_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      strb_q       <= '0;
      cnt_q        <= '0;
      hid_en_q     <= 1'b0;
      hid_we_q     <= '0;
      hid_addr_q   <= '0;
      hid_wrdata_q <= '0;
      bvalid_q     <= 1'b0;
      bresp_q      <= '0;
      rvalid_q     <= 1'b0;
      rresp_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      arb_wr_q     <= arb_wr_d;
      hit_q        <= hit_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      strb_q       <= strb_d;
      cnt_q        <= cnt_d;
      hid_en_q     <= hid_en_d;
      hid_we_q     <= hid_we_d;
      hid_addr_q   <= hid_addr_d;
      hid_wrdata_q <= hid_wrdata_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      rvalid_q     <= rvalid_d;
      rresp_q      <= rresp_d;
      rdata_q      <= rdata_d;
    end
  end

  assign s_awready  = wr_acc_c;
  assign s_wready   = wr_acc_c;
  assign s_arready  = rd_acc_c;
  assign s_bvalid   = bvalid_q;
  assign s_bresp    = bresp_q;
  assign s_rvalid   = rvalid_q;
  assign s_rresp    = rresp_q;
  assign s_rdata    = rdata_q;
  assign hid_en     = hid_en_q;
  assign hid_we     = hid_we_q;
  assign hid_addr   = hid_addr_q;
  assign hid_wrdata = hid_wrdata_q;

endmodule

// File: tb/tb_hid_axil_bridge.sv
// Testbench for hid_axil_bridge: drives AXI4-Lite transactions, models the
// peripheral RAM behind the hid bus, and checks against a slot-level memory model.
module tb_hid_axil_bridge;
  localparam int unsigned HID_AW  = 18;
  localparam int unsigned RD_LAT  = 1;
  localparam logic [31:0] BASE    = 32'h4100_0000;
  localparam logic [13:0] BASE_HI = BASE[31:18];
  localparam int          NSLOT   = 8;

  logic              msoc_clk = 1'b0;
  logic              rstn;
  logic [31:0]       s_awaddr;
  logic              s_awvalid, s_awready;
  logic [63:0]       s_wdata;
  logic [7:0]        s_wstrb;
  logic              s_wvalid, s_wready;
  logic [1:0]        s_bresp;
  logic              s_bvalid, s_bready;
  logic [31:0]       s_araddr;
  logic              s_arvalid, s_arready;
  logic [63:0]       s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rvalid, s_rready;
  logic              hid_en;
  logic [7:0]        hid_we;
  logic [HID_AW-1:0] hid_addr;
  logic [63:0]       hid_wrdata;
  logic [63:0]       hid_rddata;

  int errors = 0;
  int checks = 0;

  always #5 msoc_clk = ~msoc_clk;

  hid_axil_bridge #(.BASE(BASE), .HID_AW(HID_AW), .RD_LAT(RD_LAT)) dut (
    .msoc_clk(msoc_clk), .rstn(rstn),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .hid_en(hid_en), .hid_we(hid_we), .hid_addr(hid_addr), .hid_wrdata(hid_wrdata),
    .hid_rddata(hid_rddata)
  );

  // Peripheral RAM: byte-enabled writes, read data one cycle after hid_en,
  // garbage on every other cycle so mistimed capture shows up.
  logic [63:0]       pmem [0:32767];
  logic              pl_en = 1'b0;
  logic [HID_AW-1:0] pl_addr;
  logic [63:0]       pl_data;

  function automatic logic [63:0] merge_bytes(input logic [63:0] old, input logic [63:0] nw,
                                              input logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  always @(posedge msoc_clk) begin
    hid_rddata <= 64'hDEAD_BEEF_0BAD_F00D;
    if (pl_en) pmem[pl_addr[17:3]] <= pl_data;
    else if (hid_en && hid_we != 8'h00)
      pmem[hid_addr[17:3]] <= merge_bytes(pmem[hid_addr[17:3]], hid_wrdata, hid_we);
    if (hid_en && hid_we == 8'h00) hid_rddata <= pmem[hid_addr[17:3]];
  end

  // hid bus monitor
  int                en_cnt  = 0;
  int                we_leak = 0;
  logic [7:0]        mon_we;
  logic [HID_AW-1:0] mon_addr;
  logic [63:0]       mon_wrdata;

  always @(negedge msoc_clk) begin
    if (hid_en === 1'b1) begin
      en_cnt     <= en_cnt + 1;
      mon_we     <= hid_we;
      mon_addr   <= hid_addr;
      mon_wrdata <= hid_wrdata;
    end else if (hid_we !== 8'h00) begin
      we_leak <= we_leak + 1;
    end
  end

  // Reference model: contents of the slots inside the window
  logic [HID_AW-1:0] addr_tab [NSLOT];
  logic [63:0]       ref_mem  [NSLOT];

  initial begin
    addr_tab[0] = 18'h00000; addr_tab[1] = 18'h00008; addr_tab[2] = 18'h10008;
    addr_tab[3] = 18'h30000; addr_tab[4] = 18'h3FFF8; addr_tab[5] = 18'h01230;
    addr_tab[6] = 18'h20000; addr_tab[7] = 18'h0FFF8;
  end

  task automatic preload(input int s, input logic [63:0] d);
    @(posedge msoc_clk); #1;
    pl_en = 1'b1; pl_addr = addr_tab[s]; pl_data = d;
    @(posedge msoc_clk); #1;
    pl_en = 1'b0;
    ref_mem[s] = d;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] be,
                          output logic [1:0] resp, output int lat, output bit to);
    int n;
    to = 1'b0; lat = 0; resp = 2'bxx; n = 0;
    @(posedge msoc_clk); #1;
    s_awaddr = a; s_awvalid = 1'b1; s_wdata = d; s_wstrb = be; s_wvalid = 1'b1;
    do begin @(negedge msoc_clk); n++; end while (!(s_awready && s_wready) && n < 100);
    if (!(s_awready && s_wready)) begin
      to = 1'b1; s_awvalid = 1'b0; s_wvalid = 1'b0; return;
    end
    @(posedge msoc_clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    do begin @(negedge msoc_clk); lat++; end while (!s_bvalid && lat < 100);
    if (!s_bvalid) begin to = 1'b1; return; end
    resp = s_bresp;
    s_bready = 1'b1;
    @(posedge msoc_clk); #1;
    s_bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [63:0] d, output logic [1:0] resp,
                         output int lat, output bit to);
    int n;
    to = 1'b0; lat = 0; resp = 2'bxx; d = 'x; n = 0;
    @(posedge msoc_clk); #1;
    s_araddr = a; s_arvalid = 1'b1;
    do begin @(negedge msoc_clk); n++; end while (!s_arready && n < 100);
    if (!s_arready) begin to = 1'b1; s_arvalid = 1'b0; return; end
    @(posedge msoc_clk); #1;
    s_arvalid = 1'b0;
    do begin @(negedge msoc_clk); lat++; end while (!s_rvalid && lat < 100);
    if (!s_rvalid) begin to = 1'b1; return; end
    d = s_rdata; resp = s_rresp;
    s_rready = 1'b1;
    @(posedge msoc_clk); #1;
    s_rready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #12;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    #1;
    checks++;
    if ({s_awready, s_wready, s_arready} !== 3'b000) begin
      errors++; $display("FAIL reset_ready: got %b exp 000", {s_awready, s_wready, s_arready});
    end
    checks++;
    if ({s_bvalid, s_rvalid, hid_en} !== 3'b000) begin
      errors++; $display("FAIL reset_valid: got %b exp 000", {s_bvalid, s_rvalid, hid_en});
    end
    checks++;
    if ({hid_we, hid_addr, hid_wrdata, s_rdata, s_bresp, s_rresp} !== '0) begin
      errors++; $display("FAIL reset_data: we=%h addr=%h wd=%h rd=%h bresp=%b rresp=%b exp all 0",
                         hid_we, hid_addr, hid_wrdata, s_rdata, s_bresp, s_rresp);
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    @(negedge msoc_clk);
    rstn = 1'b1;
    repeat (2) @(negedge msoc_clk);
  endtask

  task automatic test_write();
    logic [1:0] r; int lat; bit to; int e0;
    e0 = en_cnt;
    do_write(BASE + 32'h1_0008, 64'h41, 8'hFF, r, lat, to);
    ref_mem[2] = 64'h41;
    checks++;
    if (to || r !== 2'b00 || lat != 3) begin
      errors++; $display("FAIL write_basic: to=%0d bresp=%b lat=%0d exp bresp 00 lat 3", to, r, lat);
    end
    checks++;
    if (en_cnt - e0 != 1) begin
      errors++; $display("FAIL write_en_count: got %0d exp 1", en_cnt - e0);
    end
    checks++;
    if (mon_we !== 8'hFF || mon_addr !== 18'h10008 || mon_wrdata !== 64'h41) begin
      errors++; $display("FAIL write_hid: we=%h addr=%h wd=%h exp ff 10008 41", mon_we, mon_addr, mon_wrdata);
    end
  endtask

  task automatic test_read();
    logic [63:0] d; logic [1:0] r; int lat; bit to; int e0;
    e0 = en_cnt;
    do_read(32'h4103_0000, d, r, lat, to);
    checks++;
    if (to || d !== 64'h123 || r !== 2'b00) begin
      errors++; $display("FAIL read_basic: to=%0d rdata=%h rresp=%b exp 123 00", to, d, r);
    end
    checks++;
    if (lat != RD_LAT + 2) begin
      errors++; $display("FAIL read_latency: got %0d exp %0d", lat, RD_LAT + 2);
    end
    checks++;
    if (en_cnt - e0 != 1 || mon_we !== 8'h00 || mon_addr !== 18'h30000) begin
      errors++; $display("FAIL read_hid: en=%0d we=%h addr=%h exp 1 00 30000", en_cnt - e0, mon_we, mon_addr);
    end
  endtask

  task automatic test_arbitration();
    int n; int e0; logic [63:0] wd1, wd2;
    wd1 = {$urandom, $urandom}; wd2 = {$urandom, $urandom};
    e0 = en_cnt;
    @(posedge msoc_clk); #1;
    s_awaddr = BASE | 32'(addr_tab[6]); s_wdata = wd1; s_wstrb = 8'hFF;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    s_araddr = BASE | 32'(addr_tab[7]); s_arvalid = 1'b1;
    n = 0;
    do begin @(negedge msoc_clk); n++; end while (!(s_awready || s_wready || s_arready) && n < 50);
    checks++;
    if ({s_awready, s_wready, s_arready} !== 3'b110) begin
      errors++; $display("FAIL arb_first: got aw/w/ar=%b exp 110", {s_awready, s_wready, s_arready});
    end
    @(posedge msoc_clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    n = 0;
    do begin @(negedge msoc_clk); n++; end while (!s_bvalid && n < 50);
    checks++;
    if (s_bvalid !== 1'b1 || s_bresp !== 2'b00) begin
      errors++; $display("FAIL arb_first_b: bvalid=%b bresp=%b exp 1 00", s_bvalid, s_bresp);
    end
    s_bready = 1'b1;
    @(posedge msoc_clk); #1;
    s_bready = 1'b0;
    ref_mem[6] = wd1;
    checks++;
    if (en_cnt - e0 != 1 || mon_addr !== addr_tab[6]) begin
      errors++; $display("FAIL arb_first_en: en=%0d addr=%h exp 1 %h", en_cnt - e0, mon_addr, addr_tab[6]);
    end
    // Second contention: read pending all along, write re-presented in IDLE
    e0 = en_cnt;
    s_wdata = wd2; s_awvalid = 1'b1; s_wvalid = 1'b1;
    @(negedge msoc_clk);
    checks++;
    if ({s_awready, s_wready, s_arready} !== 3'b001) begin
      errors++; $display("FAIL arb_second: got aw/w/ar=%b exp 001", {s_awready, s_wready, s_arready});
    end
    @(posedge msoc_clk); #1;
    s_arvalid = 1'b0;
    n = 0;
    do begin @(negedge msoc_clk); n++; end while (!s_rvalid && n < 50);
    checks++;
    if (s_rvalid !== 1'b1 || s_rdata !== ref_mem[7] || s_rresp !== 2'b00) begin
      errors++; $display("FAIL arb_second_r: rvalid=%b rdata=%h rresp=%b exp 1 %h 00",
                         s_rvalid, s_rdata, s_rresp, ref_mem[7]);
    end
    s_rready = 1'b1;
    @(posedge msoc_clk); #1;
    s_rready = 1'b0;
    checks++;
    if (en_cnt - e0 != 1 || mon_we !== 8'h00) begin
      errors++; $display("FAIL arb_second_en: en=%0d we=%h exp 1 00", en_cnt - e0, mon_we);
    end
    // The held write now drains
    e0 = en_cnt;
    n = 0;
    do begin @(negedge msoc_clk); n++; end while (!(s_awready && s_wready) && n < 50);
    @(posedge msoc_clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    n = 0;
    do begin @(negedge msoc_clk); n++; end while (!s_bvalid && n < 50);
    checks++;
    if (s_bvalid !== 1'b1 || s_bresp !== 2'b00) begin
      errors++; $display("FAIL arb_drain_b: bvalid=%b bresp=%b exp 1 00", s_bvalid, s_bresp);
    end
    s_bready = 1'b1;
    @(posedge msoc_clk); #1;
    s_bready = 1'b0;
    ref_mem[6] = wd2;
    checks++;
    if (en_cnt - e0 != 1 || mon_wrdata !== wd2) begin
      errors++; $display("FAIL arb_drain_en: en=%0d wd=%h exp 1 %h", en_cnt - e0, mon_wrdata, wd2);
    end
  endtask

  task automatic test_decode_miss();
    logic [63:0] d; logic [1:0] r; int lat; bit to; int e0;
    e0 = en_cnt;
    do_read(32'h5000_0000, d, r, lat, to);
    checks++;
    if (to || r !== 2'b10 || d !== 64'h0) begin
      errors++; $display("FAIL miss_read: to=%0d rresp=%b rdata=%h exp 10 0", to, r, d);
    end
    do_write(32'h5000_0000, 64'hFFFF_0000_1234_5678, 8'hFF, r, lat, to);
    checks++;
    if (to || r !== 2'b10) begin
      errors++; $display("FAIL miss_write: to=%0d bresp=%b exp 10", to, r);
    end
    checks++;
    if (en_cnt != e0) begin
      errors++; $display("FAIL miss_no_en: got %0d strobes exp 0", en_cnt - e0);
    end
  endtask

  task automatic test_rready_stall();
    logic [63:0] d0, d; logic [1:0] r; int n;
    @(posedge msoc_clk); #1;
    s_araddr = BASE | 32'(addr_tab[1]); s_arvalid = 1'b1;
    n = 0;
    do begin @(negedge msoc_clk); n++; end while (!s_arready && n < 50);
    @(posedge msoc_clk); #1;
    s_arvalid = 1'b0;
    n = 0;
    do begin @(negedge msoc_clk); n++; end while (!s_rvalid && n < 50);
    d0 = s_rdata;
    checks++;
    if (s_rvalid !== 1'b1 || d0 !== ref_mem[1]) begin
      errors++; $display("FAIL stall_first: rvalid=%b rdata=%h exp 1 %h", s_rvalid, d0, ref_mem[1]);
    end
    s_araddr = BASE | 32'(addr_tab[4]); s_arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge msoc_clk);
      checks++;
      if (s_rvalid !== 1'b1 || s_rdata !== d0 || s_rresp !== 2'b00 || s_arready !== 1'b0) begin
        errors++; $display("FAIL stall_hold[%0d]: rvalid=%b rdata=%h rresp=%b arready=%b exp 1 %h 00 0",
                           i, s_rvalid, s_rdata, s_rresp, s_arready, d0);
      end
    end
    s_rready = 1'b1;
    @(posedge msoc_clk); #1;
    s_rready = 1'b0;
    n = 0;
    do begin @(negedge msoc_clk); n++; end while (!s_arready && n < 50);
    @(posedge msoc_clk); #1;
    s_arvalid = 1'b0;
    n = 0;
    do begin @(negedge msoc_clk); n++; end while (!s_rvalid && n < 50);
    d = s_rdata; r = s_rresp;
    checks++;
    if (s_rvalid !== 1'b1 || d !== ref_mem[4] || r !== 2'b00) begin
      errors++; $display("FAIL stall_second: rvalid=%b rdata=%h rresp=%b exp 1 %h 00", s_rvalid, d, r, ref_mem[4]);
    end
    s_rready = 1'b1;
    @(posedge msoc_clk); #1;
    s_rready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n; int e0; bit saw_rvalid; logic [1:0] r; int lat; bit to;
    @(posedge msoc_clk); #1;
    s_araddr = BASE | 32'(addr_tab[0]); s_arvalid = 1'b1;
    n = 0;
    do begin @(negedge msoc_clk); n++; end while (!s_arready && n < 50);
    @(posedge msoc_clk); #1;
    s_arvalid = 1'b0;
    @(negedge msoc_clk);
    @(negedge msoc_clk);
    rstn = 1'b0;
    #1;
    checks++;
    if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid, hid_en} !== 6'b0) begin
      errors++; $display("FAIL midrst_valid: got %b exp 000000",
                         {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, hid_en});
    end
    checks++;
    if ({hid_we, hid_addr, hid_wrdata, s_rdata, s_bresp, s_rresp} !== '0) begin
      errors++; $display("FAIL midrst_data: we=%h addr=%h wd=%h rd=%h exp all 0",
                         hid_we, hid_addr, hid_wrdata, s_rdata);
    end
    e0 = en_cnt;
    saw_rvalid = 1'b0;
    repeat (3) @(negedge msoc_clk);
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge msoc_clk);
      if (s_rvalid === 1'b1) saw_rvalid = 1'b1;
    end
    checks++;
    if (en_cnt != e0 || saw_rvalid) begin
      errors++; $display("FAIL midrst_quiet: strobes=%0d rvalid_seen=%0d exp 0 0", en_cnt - e0, saw_rvalid);
    end
    e0 = en_cnt;
    do_write(BASE | 32'(addr_tab[5]), 64'h55, 8'h01, r, lat, to);
    ref_mem[5] = merge_bytes(ref_mem[5], 64'h55, 8'h01);
    checks++;
    if (to || r !== 2'b00 || lat != 3 || en_cnt - e0 != 1) begin
      errors++; $display("FAIL midrst_write: to=%0d bresp=%b lat=%0d en=%0d exp 00 3 1", to, r, lat, en_cnt - e0);
    end
    checks++;
    if (mon_we !== 8'h01 || mon_wrdata !== 64'h55 || mon_addr !== addr_tab[5]) begin
      errors++; $display("FAIL midrst_hid: we=%h wd=%h addr=%h exp 01 55 %h", mon_we, mon_wrdata, mon_addr, addr_tab[5]);
    end
  endtask

  task automatic test_random();
    logic [63:0] d, wd; logic [1:0] r; int lat; bit to; int e0, s; bit hit, is_wr;
    logic [7:0] be; logic [13:0] hi; logic [31:0] a;
    for (int it = 0; it < 30; it++) begin
      is_wr = 1'($urandom_range(0, 1));
      hit   = ($urandom_range(0, 3) != 0);
      s     = int'($urandom_range(0, NSLOT - 1));
      hi    = 14'($urandom_range(0, 16383));
      if (hi == BASE_HI) hi = hi ^ 14'h1;
      a     = hit ? (BASE | 32'(addr_tab[s])) : {hi, addr_tab[s]};
      e0    = en_cnt;
      if (is_wr) begin
        wd = {$urandom, $urandom};
        be = 8'($urandom_range(0, 255));
        do_write(a, wd, be, r, lat, to);
        if (hit) ref_mem[s] = merge_bytes(ref_mem[s], wd, be);
        checks++;
        if (to || r !== (hit ? 2'b00 : 2'b10) || en_cnt - e0 != int'(hit)) begin
          errors++; $display("FAIL rand_wr[%0d]: to=%0d bresp=%b en=%0d hit=%0d", it, to, r, en_cnt - e0, hit);
        end
        if (hit) begin
          checks++;
          if (mon_we !== be || mon_addr !== addr_tab[s] || mon_wrdata !== wd || lat != 3) begin
            errors++; $display("FAIL rand_wr_hid[%0d]: we=%h addr=%h wd=%h lat=%0d exp %h %h %h 3",
                               it, mon_we, mon_addr, mon_wrdata, lat, be, addr_tab[s], wd);
          end
        end
      end else begin
        do_read(a, d, r, lat, to);
        checks++;
        if (to || r !== (hit ? 2'b00 : 2'b10) || d !== (hit ? ref_mem[s] : 64'h0)) begin
          errors++; $display("FAIL rand_rd[%0d]: to=%0d rresp=%b rdata=%h exp %h hit=%0d",
                             it, to, r, d, hit ? ref_mem[s] : 64'h0, hit);
        end
        checks++;
        if (en_cnt - e0 != int'(hit) || (hit && (lat != RD_LAT + 2 || mon_addr !== addr_tab[s]))) begin
          errors++; $display("FAIL rand_rd_hid[%0d]: en=%0d lat=%0d addr=%h hit=%0d", it, en_cnt - e0, lat, mon_addr, hit);
        end
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0; s_bready = 1'b0;
    s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    test_reset();
    for (int i = 0; i < NSLOT; i++) preload(i, {$urandom, $urandom} | 64'h1);
    preload(3, 64'h123);
    test_write();
    test_read();
    test_arbitration();
    test_decode_miss();
    test_rready_stall();
    test_reset_mid();
    test_random();
    @(negedge msoc_clk);
    checks++;
    if (we_leak != 0) begin
      errors++; $display("FAIL we_without_en: got %0d cycles exp 0", we_leak);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
    $fatal(1);
  end

endmodule
